// File: rtl/cond_branch_fsm_if.sv
// Decode/ALU-side signal bundle for cond_branch_fsm.
// slave = the FSM, master = whatever drives decode and ALU results.
interface cond_branch_fsm_if #(
    parameter int DATA_W = 16
);
    logic              instr_valid_in;
    logic              instr_ready_out;
    logic              we_reg_in;
    logic              br_in;
    logic [2:0]        nzp_dec_in;
    logic [DATA_W-1:0] alu_result_in;
    logic              alu_valid_in;
    logic              reg_we_out;
    logic              pc_latch_out;
    logic              pc_ctl_0_out;
    logic [2:0]        cc_out;
    logic [1:0]        state_out;
    logic              err_out;

    modport slave (
        input  instr_valid_in, we_reg_in, br_in, nzp_dec_in, alu_result_in, alu_valid_in,
        output instr_ready_out, reg_we_out, pc_latch_out, pc_ctl_0_out, cc_out, state_out, err_out
    );

    modport master (
        output instr_valid_in, we_reg_in, br_in, nzp_dec_in, alu_result_in, alu_valid_in,
        input  instr_ready_out, reg_we_out, pc_latch_out, pc_ctl_0_out, cc_out, state_out, err_out
    );
endinterface

// File: rtl/cond_branch_fsm.sv
// Condition-code / conditional-branch sequencer: accepts one instruction, waits for the ALU, commits.
// Define COND_BRANCH_TIMEOUT_EN to build the ALU-wait timeout and sticky err_out.
//
// state  | meaning
// IDLE   | ready for an instruction (instr_ready_out=1)
// EXEC   | write instruction waiting for alu_valid_in
// COMMIT | one-cycle PC advance / register write / branch decision
module cond_branch_fsm #(
    parameter int DATA_W      = 16,
    parameter int ALU_TIMEOUT = 15
) (
    input  logic              clka,
    input  logic              reset_n_in,
    cond_branch_fsm_if.slave  bus
);
    if (DATA_W < 2 || DATA_W > 64) begin : g_bad_data_w
        $error("cond_branch_fsm: DATA_W out of range 2..64");
    end
    if (ALU_TIMEOUT < 1 || ALU_TIMEOUT > 255) begin : g_bad_alu_timeout
        $error("cond_branch_fsm: ALU_TIMEOUT out of range 1..255");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        EXEC   = 2'b01,
        COMMIT = 2'b10
    } state_t;

    state_t     state_q, state_d;
    logic       we_q, br_q, alu_done_q;
    logic [2:0] nzp_q;
    logic [2:0] cc_q;
    logic [2:0] cc_new;
    logic       handshake, alu_take, timeout;

    assign handshake = bus.instr_valid_in && (state_q == IDLE);
    assign alu_take  = bus.alu_valid_in && (state_q == EXEC);

    always_comb begin
        cc_new    = 3'b000;
        cc_new[2] = bus.alu_result_in[DATA_W-1];
        cc_new[1] = ~|bus.alu_result_in;
        cc_new[0] = ~cc_new[2] & ~cc_new[1];
    end

`ifdef COND_BRANCH_TIMEOUT_EN
    logic [7:0] tmr_q;
    logic       err_q;

    // A result arriving on the terminal cycle still wins over the timeout.
    assign timeout = (state_q == EXEC) && !bus.alu_valid_in && (tmr_q == 8'd0);

    always_ff @(posedge clka or negedge reset_n_in) begin
        if (!reset_n_in) begin
            tmr_q <= 8'd0;
            err_q <= 1'b0;
        end else begin
            if (handshake && bus.we_reg_in)
                tmr_q <= 8'(ALU_TIMEOUT - 1);
            else if (state_q == EXEC && tmr_q != 8'd0)
                tmr_q <= tmr_q - 8'd1;
            if (timeout)
                err_q <= 1'b1;
        end
    end

    assign bus.err_out = err_q;
`else
    assign timeout     = 1'b0;
    assign bus.err_out = 1'b0;
`endif

    always_ff @(posedge clka or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            br_q       <= 1'b0;
            nzp_q      <= 3'b000;
            alu_done_q <= 1'b0;
            cc_q       <= 3'b000;
        end else begin
            state_q <= state_d;
            if (handshake) begin
                we_q       <= bus.we_reg_in;
                br_q       <= bus.br_in;
                nzp_q      <= bus.nzp_dec_in;
                alu_done_q <= 1'b0;
            end
            if (alu_take) begin
                alu_done_q <= 1'b1;
                cc_q       <= cc_new;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (handshake) state_d = bus.we_reg_in ? EXEC : COMMIT;
            EXEC:    if (alu_take || timeout) state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Branch decision uses cc_q, which already holds this instruction's result.
    assign bus.instr_ready_out = (state_q == IDLE);
    assign bus.pc_latch_out    = (state_q == COMMIT);
    assign bus.reg_we_out      = (state_q == COMMIT) && we_q && alu_done_q;
    assign bus.pc_ctl_0_out    = (state_q == COMMIT) && br_q && |(nzp_q & cc_q);
    assign bus.cc_out          = cc_q;
    assign bus.state_out       = state_q;
endmodule

// File: tb/tb_cond_branch_fsm.sv
// Directed table-driven bench for cond_branch_fsm (DATA_W=16, ALU_TIMEOUT=4).
module tb_cond_branch_fsm;
    logic clka = 1'b0;
    logic reset_n = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clka = ~clka;

    cond_branch_fsm_if #(.DATA_W(16)) bus ();

    cond_branch_fsm #(.DATA_W(16), .ALU_TIMEOUT(4)) dut (
        .clka       (clka),
        .reset_n_in (reset_n),
        .bus        (bus)
    );

    typedef struct {
        logic        we;
        logic        br;
        logic [2:0]  nzp;
        int          delay;
        logic [15:0] res;
        logic [2:0]  exp_cc;
        logic        exp_reg_we;
        logic        exp_pc_ctl;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        check($sformatf("v%0d ready", idx), 64'(bus.instr_ready_out), 64'd1);
        bus.instr_valid_in = 1'b1;
        bus.we_reg_in      = v.we;
        bus.br_in          = v.br;
        bus.nzp_dec_in     = v.nzp;
        @(negedge clka);
        bus.instr_valid_in = 1'b0;
        if (v.we) begin
            for (int d = 0; d < v.delay; d++) begin
                check($sformatf("v%0d wait state", idx), 64'(bus.state_out), 64'h1);
                check($sformatf("v%0d wait strobe", idx), 64'(bus.pc_latch_out | bus.reg_we_out), 64'd0);
                @(negedge clka);
            end
            check($sformatf("v%0d exec state", idx), 64'(bus.state_out), 64'h1);
            bus.alu_valid_in  = 1'b1;
            bus.alu_result_in = v.res;
            @(negedge clka);
            bus.alu_valid_in  = 1'b0;
        end
        check($sformatf("v%0d commit state", idx), 64'(bus.state_out), 64'h2);
        check($sformatf("v%0d pc_latch", idx), 64'(bus.pc_latch_out), 64'd1);
        check($sformatf("v%0d reg_we", idx), 64'(bus.reg_we_out), 64'(v.exp_reg_we));
        check($sformatf("v%0d pc_ctl", idx), 64'(bus.pc_ctl_0_out), 64'(v.exp_pc_ctl));
        check($sformatf("v%0d cc", idx), 64'(bus.cc_out), 64'(v.exp_cc));
        @(negedge clka);
        check($sformatf("v%0d idle state", idx), 64'(bus.state_out), 64'h0);
        check($sformatf("v%0d idle strobe", idx), 64'(bus.pc_latch_out | bus.reg_we_out | bus.pc_ctl_0_out), 64'd0);
    endtask

    initial begin
        //          we    br    nzp     dly res       cc      rwe   pctl
        vecs[0] = '{1'b1, 1'b0, 3'b000, 1, 16'h8000, 3'b100, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 3'b010, 0, 16'h0000, 3'b010, 1'b1, 1'b1};
        vecs[2] = '{1'b1, 1'b0, 3'b111, 2, 16'h0005, 3'b001, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 3'b001, 0, 16'h0000, 3'b001, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 1'b1, 3'b110, 0, 16'h0000, 3'b001, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 3'b101, 1, 16'hFFFF, 3'b100, 1'b1, 1'b1};
        vecs[6] = '{1'b0, 1'b0, 3'b111, 0, 16'h0000, 3'b100, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 1'b1, 3'b011, 0, 16'h7FFF, 3'b001, 1'b1, 1'b1};
        vecs[8] = '{1'b1, 1'b1, 3'b100, 3, 16'h0001, 3'b001, 1'b1, 1'b0};

        bus.instr_valid_in = 1'b0;
        bus.we_reg_in      = 1'b0;
        bus.br_in          = 1'b0;
        bus.nzp_dec_in     = 3'b000;
        bus.alu_result_in  = 16'h0000;
        bus.alu_valid_in   = 1'b0;
        reset_n            = 1'b0;
        #2;
        check("rst state", 64'(bus.state_out), 64'h0);
        check("rst cc", 64'(bus.cc_out), 64'h0);
        check("rst ready", 64'(bus.instr_ready_out), 64'd1);
        check("rst err", 64'(bus.err_out), 64'd0);
        check("rst strobes", 64'(bus.pc_latch_out | bus.reg_we_out | bus.pc_ctl_0_out), 64'd0);
        @(negedge clka);
        reset_n = 1'b1;
        @(negedge clka);

        for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

        // Reset in the middle of EXEC, then stray inputs.
        bus.instr_valid_in = 1'b1;
        bus.we_reg_in      = 1'b1;
        bus.br_in          = 1'b0;
        bus.nzp_dec_in     = 3'b000;
        @(negedge clka);
        bus.instr_valid_in = 1'b0;
        check("mid exec state", 64'(bus.state_out), 64'h1);
        reset_n = 1'b0;
        #1;
        check("mid rst state", 64'(bus.state_out), 64'h0);
        check("mid rst cc", 64'(bus.cc_out), 64'h0);
        check("mid rst ready", 64'(bus.instr_ready_out), 64'd1);
        @(negedge clka);
        check("mid rst strobe", 64'(bus.pc_latch_out | bus.reg_we_out), 64'd0);
        reset_n = 1'b1;
        @(negedge clka);
        check("post rst idle", 64'(bus.state_out), 64'h0);

        bus.instr_valid_in = 1'b1;
        bus.we_reg_in      = 1'b1;
        bus.br_in          = 1'b0;
        bus.nzp_dec_in     = 3'b000;
        @(negedge clka);
        check("stray exec", 64'(bus.state_out), 64'h1);
        check("stray ready", 64'(bus.instr_ready_out), 64'd0);
        bus.instr_valid_in = 1'b1;
        bus.we_reg_in      = 1'b0;
        bus.br_in          = 1'b1;
        bus.nzp_dec_in     = 3'b010;
        @(negedge clka);
        bus.instr_valid_in = 1'b0;
        check("stray still exec", 64'(bus.state_out), 64'h1);
        bus.alu_valid_in  = 1'b1;
        bus.alu_result_in = 16'h0000;
        @(negedge clka);
        bus.alu_valid_in  = 1'b0;
        check("stray commit", 64'(bus.state_out), 64'h2);
        check("stray reg_we", 64'(bus.reg_we_out), 64'd1);
        check("stray pc_ctl", 64'(bus.pc_ctl_0_out), 64'd0);
        check("stray cc", 64'(bus.cc_out), 64'h2);
        @(negedge clka);
        bus.alu_valid_in  = 1'b1;
        bus.alu_result_in = 16'h8000;
        @(negedge clka);
        bus.alu_valid_in  = 1'b0;
        check("idle alu state", 64'(bus.state_out), 64'h0);
        check("idle alu cc", 64'(bus.cc_out), 64'h2);

`ifdef COND_BRANCH_TIMEOUT_EN
        bus.instr_valid_in = 1'b1;
        bus.we_reg_in      = 1'b1;
        bus.br_in          = 1'b1;
        bus.nzp_dec_in     = 3'b010;
        @(negedge clka);
        bus.instr_valid_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("to exec%0d", i), 64'(bus.state_out), 64'h1);
            check($sformatf("to err%0d", i), 64'(bus.err_out), 64'd0);
            @(negedge clka);
        end
        check("to commit", 64'(bus.state_out), 64'h2);
        check("to reg_we", 64'(bus.reg_we_out), 64'd0);
        check("to pc_latch", 64'(bus.pc_latch_out), 64'd1);
        check("to pc_ctl", 64'(bus.pc_ctl_0_out), 64'd1);
        check("to cc", 64'(bus.cc_out), 64'h2);
        check("to err", 64'(bus.err_out), 64'd1);
        @(negedge clka);
        check("to idle", 64'(bus.state_out), 64'h0);
        check("to err held", 64'(bus.err_out), 64'd1);
        run_vec(99, vecs[1]);
        check("to err sticky", 64'(bus.err_out), 64'd1);
        reset_n = 1'b0;
        #1;
        check("to err cleared", 64'(bus.err_out), 64'd0);
        @(negedge clka);
        reset_n = 1'b1;
        @(negedge clka);
`else
        bus.instr_valid_in = 1'b1;
        bus.we_reg_in      = 1'b1;
        bus.br_in          = 1'b0;
        bus.nzp_dec_in     = 3'b000;
        @(negedge clka);
        bus.instr_valid_in = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("wait exec%0d", i), 64'(bus.state_out), 64'h1);
            check($sformatf("wait err%0d", i), 64'(bus.err_out), 64'd0);
            @(negedge clka);
        end
        bus.alu_valid_in  = 1'b1;
        bus.alu_result_in = 16'h0001;
        @(negedge clka);
        bus.alu_valid_in  = 1'b0;
        check("wait commit", 64'(bus.state_out), 64'h2);
        check("wait reg_we", 64'(bus.reg_we_out), 64'd1);
        check("wait cc", 64'(bus.cc_out), 64'h1);
        @(negedge clka);
        check("wait idle", 64'(bus.state_out), 64'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
